// File: rtl/fetch_sched.sv
// fetch_sched: front-end pcGen sequencer. Picks the next fetch PC (commit flush >
// iqueue branch redirect > sequential +8), issues epoch-tagged requests under a
// credit limit, drops wrong-path responses and buffers good ones for the iqueue.
// Optional build macro: FETCH_SCHED_PERF_EN adds saturating perf counter outputs.
module fetch_sched #(
   parameter logic [63:0] RESET_PC   = 64'h8000_0000,
   parameter int unsigned MAX_OUTSTD = 2,
   parameter int unsigned EPOCH_W    = 2
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               flush,
   input  logic [63:0]        flush_pc,
   input  logic               branch_pc_valid,
   input  logic [63:0]        branch_pc,
   output logic               imem_req_valid,
   output logic [63:0]        imem_req_pc,
   output logic [EPOCH_W-1:0] imem_req_epoch,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [63:0]        imem_rsp_instr,
   input  logic [EPOCH_W-1:0] imem_rsp_epoch,
   output logic               if_iq_valid,
   output logic [63:0]        if_iq_pc,
   output logic [63:0]        if_iq_instr,
   input  logic               if_iq_ready
`ifdef FETCH_SCHED_PERF_EN
   ,
   output logic [31:0]        perf_issue_cnt,
   output logic [31:0]        perf_drop_cnt,
   output logic [31:0]        perf_redirect_cnt
`endif
);

   localparam int unsigned      CNT_W    = $clog2(MAX_OUTSTD + 1);
   localparam int unsigned      PTR_W    = (MAX_OUTSTD > 1) ? $clog2(MAX_OUTSTD) : 1;
   localparam logic [CNT_W:0]   CREDITS  = (CNT_W + 1)'(MAX_OUTSTD);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTD - 1);

   typedef enum logic {BOOT, RUN} state_t;
   state_t state_q, state_d;

   logic [63:0]        pc_next;
   logic [EPOCH_W-1:0] cur_epoch;
   logic [CNT_W-1:0]   inflight;
   logic [CNT_W-1:0]   rsp_count;

   // PC FIFO: one entry per request in flight, its occupancy is 'inflight'
   logic [63:0]        pcf_pc [MAX_OUTSTD];
   logic [EPOCH_W-1:0] pcf_ep [MAX_OUTSTD];
   logic [PTR_W-1:0]   pcf_wr, pcf_rd;

   // Response FIFO: good-path words waiting for the iqueue
   logic [63:0]        rsf_pc    [MAX_OUTSTD];
   logic [63:0]        rsf_instr [MAX_OUTSTD];
   logic [PTR_W-1:0]   rsf_wr, rsf_rd;

   logic               redirect;
   logic [63:0]        redirect_pc;
   logic [CNT_W:0]     credit_used;
   logic               issue, rsp_take, rsp_keep, iq_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // BOOT holds for exactly one cycle after reset, then RUN forever
   always_comb begin
      state_d = state_q;
      if (state_q == BOOT) state_d = RUN;
   end

   // Request/response/output decode; iqueue outputs depend on registered state only
   always_comb begin
      redirect       = flush | branch_pc_valid;
      redirect_pc    = flush ? flush_pc : branch_pc;
      credit_used    = {1'b0, inflight} + {1'b0, rsp_count};
      imem_req_valid = (state_q == RUN) && !redirect && (credit_used < CREDITS);
      imem_req_pc    = {pc_next[63:3], 3'b000};
      imem_req_epoch = cur_epoch;
      issue          = imem_req_valid && imem_req_ready;
      rsp_take       = imem_rsp_valid && (inflight != '0);
      rsp_keep       = rsp_take && !redirect && (imem_rsp_epoch == cur_epoch)
                       && (pcf_ep[pcf_rd] == cur_epoch);
      if_iq_valid    = (rsp_count != '0);
      if_iq_pc       = if_iq_valid ? rsf_pc[rsf_rd]    : '0;
      if_iq_instr    = if_iq_valid ? rsf_instr[rsf_rd] : '0;
      iq_pop         = if_iq_valid && if_iq_ready;
   end

   // State, PC sequencing, epoch, counters and FIFO pointers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= BOOT;
         pc_next   <= RESET_PC;
         cur_epoch <= '0;
         inflight  <= '0;
         rsp_count <= '0;
         pcf_wr    <= '0;
         pcf_rd    <= '0;
         rsf_wr    <= '0;
         rsf_rd    <= '0;
      end else begin
         state_q <= state_d;
         if (redirect) begin
            pc_next   <= redirect_pc;
            cur_epoch <= cur_epoch + EPOCH_W'(1);
         end else if (issue) begin
            pc_next <= {pc_next[63:3], 3'b000} + 64'd8;
         end
         // stale requests keep draining through the PC FIFO across redirects
         if (issue)    pcf_wr <= ptr_inc(pcf_wr);
         if (rsp_take) pcf_rd <= ptr_inc(pcf_rd);
         case ({issue, rsp_take})
            2'b10:   inflight <= inflight + CNT_W'(1);
            2'b01:   inflight <= inflight - CNT_W'(1);
            default: ;
         endcase
         // a redirect empties the response FIFO, overriding any same-cycle pop
         if (redirect) begin
            rsf_wr    <= '0;
            rsf_rd    <= '0;
            rsp_count <= '0;
         end else begin
            if (rsp_keep) rsf_wr <= ptr_inc(rsf_wr);
            if (iq_pop)   rsf_rd <= ptr_inc(rsf_rd);
            case ({rsp_keep, iq_pop})
               2'b10:   rsp_count <= rsp_count + CNT_W'(1);
               2'b01:   rsp_count <= rsp_count - CNT_W'(1);
               default: ;
            endcase
         end
      end
   end

   // FIFO storage; contents are never observed unless the matching count is non-zero
   always_ff @(posedge CLK) begin
      if (issue) begin
         pcf_pc[pcf_wr] <= pc_next;
         pcf_ep[pcf_wr] <= cur_epoch;
      end
      if (rsp_keep) begin
         rsf_pc[rsf_wr]    <= pcf_pc[pcf_rd];
         rsf_instr[rsf_wr] <= imem_rsp_instr;
      end
   end

`ifdef FETCH_SCHED_PERF_EN
   // Saturating event counters for issue, stale drop and redirect cycles
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         perf_issue_cnt    <= '0;
         perf_drop_cnt     <= '0;
         perf_redirect_cnt <= '0;
      end else begin
         if (issue && perf_issue_cnt != '1)
            perf_issue_cnt <= perf_issue_cnt + 32'd1;
         if (rsp_take && !rsp_keep && perf_drop_cnt != '1)
            perf_drop_cnt <= perf_drop_cnt + 32'd1;
         if (redirect && perf_redirect_cnt != '1)
            perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_sched.sv
// tb_fetch_sched: directed bench for fetch_sched with a 1-cycle memory model
// that can hold back responses.
module tb_fetch_sched;

   logic        CLK = 1'b0;
   logic        RST;
   logic        flush;
   logic [63:0] flush_pc;
   logic        branch_pc_valid;
   logic [63:0] branch_pc;
   logic        imem_req_valid;
   logic [63:0] imem_req_pc;
   logic [1:0]  imem_req_epoch;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [63:0] imem_rsp_instr;
   logic [1:0]  imem_rsp_epoch;
   logic        if_iq_valid;
   logic [63:0] if_iq_pc;
   logic [63:0] if_iq_instr;
   logic        if_iq_ready;
`ifdef FETCH_SCHED_PERF_EN
   logic [31:0] perf_issue_cnt, perf_drop_cnt, perf_redirect_cnt;
`endif

   fetch_sched #(.RESET_PC(64'h8000_0000), .MAX_OUTSTD(2), .EPOCH_W(2)) dut (
      .CLK(CLK), .RST(RST),
      .flush(flush), .flush_pc(flush_pc),
      .branch_pc_valid(branch_pc_valid), .branch_pc(branch_pc),
      .imem_req_valid(imem_req_valid), .imem_req_pc(imem_req_pc),
      .imem_req_epoch(imem_req_epoch), .imem_req_ready(imem_req_ready),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_instr(imem_rsp_instr),
      .imem_rsp_epoch(imem_rsp_epoch),
      .if_iq_valid(if_iq_valid), .if_iq_pc(if_iq_pc), .if_iq_instr(if_iq_instr),
      .if_iq_ready(if_iq_ready)
`ifdef FETCH_SCHED_PERF_EN
      , .perf_issue_cnt(perf_issue_cnt), .perf_drop_cnt(perf_drop_cnt),
      .perf_redirect_cnt(perf_redirect_cnt)
`endif
   );

   always #5 CLK = ~CLK;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [63:0] mq_pc[$];
   logic [1:0]  mq_ep[$];
   logic [63:0] fire_pc_q[$];
   logic [1:0]  fire_ep_q[$];
   logic [63:0] pop_pc_q[$];
   logic [63:0] pop_instr_q[$];
   logic        mem_hold;
   int          max_inflight;

   function automatic logic [63:0] instr_of(input logic [63:0] a);
      return {a[31:0], ~a[31:0]};
   endfunction

   task automatic clear_logs();
      fire_pc_q.delete(); fire_ep_q.delete();
      pop_pc_q.delete();  pop_instr_q.delete();
      max_inflight = 0;
   endtask

   // One clock: sample handshakes at negedge, then update memory model after the edge
   task automatic step();
      logic s_fire, s_pop, s_rsp;
      logic [63:0] s_pc, s_ipc, s_iins, dummy_pc;
      logic [1:0] s_ep, dummy_ep;
      @(negedge CLK);
      s_fire = imem_req_valid && imem_req_ready;
      s_pc   = imem_req_pc;
      s_ep   = imem_req_epoch;
      s_pop  = if_iq_valid && if_iq_ready;
      s_ipc  = if_iq_pc;
      s_iins = if_iq_instr;
      s_rsp  = imem_rsp_valid;
      @(posedge CLK); #1;
      if (s_rsp && mq_pc.size() != 0) begin
         dummy_pc = mq_pc.pop_front();
         dummy_ep = mq_ep.pop_front();
      end
      if (s_fire) begin
         mq_pc.push_back(s_pc);      mq_ep.push_back(s_ep);
         fire_pc_q.push_back(s_pc);  fire_ep_q.push_back(s_ep);
      end
      if (s_pop) begin
         pop_pc_q.push_back(s_ipc);  pop_instr_q.push_back(s_iins);
      end
      if (mq_pc.size() > max_inflight) max_inflight = mq_pc.size();
      if (!mem_hold && mq_pc.size() != 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_instr = instr_of(mq_pc[0]);
         imem_rsp_epoch = mq_ep[0];
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_instr = '0;
         imem_rsp_epoch = '0;
      end
   endtask

   // Leaves the DUT in its BOOT cycle, 1 time unit after a clock edge
   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b1;
      flush = 1'b0; branch_pc_valid = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_instr = '0; imem_rsp_epoch = '0;
      mq_pc.delete(); mq_ep.delete();
      clear_logs();
      @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
      checks++; if (imem_req_pc !== 64'h8000_0000) begin errors++; $display("FAIL rst_req_pc: got %h want 8000_0000", imem_req_pc); end
      checks++; if (imem_req_epoch !== 2'd0) begin errors++; $display("FAIL rst_req_epoch: got %0d want 0", imem_req_epoch); end
      checks++; if (if_iq_valid !== 1'b0) begin errors++; $display("FAIL rst_iq_valid: got %b want 0", if_iq_valid); end
      checks++; if (if_iq_pc !== 64'h0 || if_iq_instr !== 64'h0) begin errors++; $display("FAIL rst_iq_data: got %h/%h want 0/0", if_iq_pc, if_iq_instr); end
      @(posedge CLK); #1;
      RST = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_no_issue: got %b want 0", imem_req_valid); end
      step();
      checks++; if (imem_req_valid !== 1'b1 || imem_req_pc !== 64'h8000_0000) begin errors++; $display("FAIL first_req: got v=%b pc=%h want v=1 pc=8000_0000", imem_req_valid, imem_req_pc); end
   endtask

   task automatic test_stream();
      do_reset();
      imem_req_ready = 1'b1; if_iq_ready = 1'b1; mem_hold = 1'b0;
      repeat (20) step();
      checks++; if (fire_pc_q.size() < 6) begin errors++; $display("FAIL stream_fire_count: got %0d want >=6", fire_pc_q.size()); end
      for (int i = 0; i < fire_pc_q.size(); i++) begin
         checks++;
         if (fire_pc_q[i] !== 64'h8000_0000 + 64'(i * 8) || fire_ep_q[i] !== 2'd0) begin
            errors++; $display("FAIL stream_req[%0d]: got %h ep%0d want %h ep0", i, fire_pc_q[i], fire_ep_q[i], 64'h8000_0000 + 64'(i * 8));
         end
      end
      checks++; if (pop_pc_q.size() < 5) begin errors++; $display("FAIL stream_pop_count: got %0d want >=5", pop_pc_q.size()); end
      for (int i = 0; i < pop_pc_q.size(); i++) begin
         checks++;
         if (pop_pc_q[i] !== 64'h8000_0000 + 64'(i * 8) || pop_instr_q[i] !== instr_of(64'h8000_0000 + 64'(i * 8))) begin
            errors++; $display("FAIL stream_iq[%0d]: got %h/%h want pc %h", i, pop_pc_q[i], pop_instr_q[i], 64'h8000_0000 + 64'(i * 8));
         end
      end
      checks++; if (max_inflight > 2) begin errors++; $display("FAIL stream_max_inflight: got %0d want <=2", max_inflight); end
   endtask

   task automatic test_stall();
      do_reset();
      imem_req_ready = 1'b1; if_iq_ready = 1'b1; mem_hold = 1'b0;
      step();            // BOOT
      step();            // 0x80000000 accepted
      imem_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (imem_req_valid !== 1'b1 || imem_req_pc !== 64'h8000_0008) begin
            errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h want v=1 pc=8000_0008", i, imem_req_valid, imem_req_pc);
         end
      end
      checks++; if (fire_pc_q.size() !== 1) begin errors++; $display("FAIL stall_no_accept: got %0d fires want 1", fire_pc_q.size()); end
      imem_req_ready = 1'b1;
      repeat (4) step();
      checks++;
      if (fire_pc_q.size() < 3 || fire_pc_q[1] !== 64'h8000_0008 || fire_pc_q[2] !== 64'h8000_0010) begin
         errors++; $display("FAIL stall_resume: got %0d fires, want 8000_0008 then 8000_0010", fire_pc_q.size());
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      imem_req_ready = 1'b1; if_iq_ready = 1'b0; mem_hold = 1'b0;
      repeat (6) step();
      checks++; if (fire_pc_q.size() !== 2) begin errors++; $display("FAIL bp_fire_count: got %0d want 2", fire_pc_q.size()); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_blocked: got %b want 0", imem_req_valid); end
      checks++; if (if_iq_valid !== 1'b1 || if_iq_pc !== 64'h8000_0000 || if_iq_instr !== instr_of(64'h8000_0000)) begin
         errors++; $display("FAIL bp_iq_head: got v=%b pc=%h instr=%h want v=1 pc=8000_0000", if_iq_valid, if_iq_pc, if_iq_instr);
      end
      if_iq_ready = 1'b1;
      step();
      if_iq_ready = 1'b0;
      #1;
      checks++; if (pop_pc_q.size() !== 1 || pop_pc_q[0] !== 64'h8000_0000) begin errors++; $display("FAIL bp_pop: got %0d pops want 1 at 8000_0000", pop_pc_q.size()); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_pc !== 64'h8000_0010) begin errors++; $display("FAIL bp_reenable: got v=%b pc=%h want v=1 pc=8000_0010", imem_req_valid, imem_req_pc); end
      checks++; if (if_iq_pc !== 64'h8000_0008) begin errors++; $display("FAIL bp_next_head: got %h want 8000_0008", if_iq_pc); end
   endtask

   task automatic test_branch();
      do_reset();
      imem_req_ready = 1'b1; if_iq_ready = 1'b1; mem_hold = 1'b1;
      repeat (3) step();  // BOOT, 0x..00, 0x..08 accepted; both held in memory
      checks++; if (fire_pc_q.size() !== 2 || fire_ep_q[0] !== 2'd0 || fire_ep_q[1] !== 2'd0) begin errors++; $display("FAIL br_pre_fires: got %0d fires want 2 at epoch 0", fire_pc_q.size()); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL br_credit_full: got %b want 0", imem_req_valid); end
      branch_pc_valid = 1'b1; branch_pc = 64'h8000_1006; mem_hold = 1'b0;
      step();
      branch_pc_valid = 1'b0;
      #1;
      checks++; if (imem_req_epoch !== 2'd1) begin errors++; $display("FAIL br_epoch: got %0d want 1", imem_req_epoch); end
      checks++; if (imem_req_pc !== 64'h8000_1000) begin errors++; $display("FAIL br_req_pc: got %h want 8000_1000", imem_req_pc); end
      clear_logs();
      repeat (8) step();
      checks++;
      if (fire_pc_q.size() < 2 || fire_pc_q[0] !== 64'h8000_1000 || fire_ep_q[0] !== 2'd1 || fire_pc_q[1] !== 64'h8000_1008) begin
         errors++; $display("FAIL br_new_reqs: got %0d fires, want 8000_1000 ep1 then 8000_1008", fire_pc_q.size());
      end
      checks++;
      if (pop_pc_q.size() < 2 || pop_pc_q[0] !== 64'h8000_1006 || pop_instr_q[0] !== instr_of(64'h8000_1000)) begin
         errors++; $display("FAIL br_first_word: got %0d pops (first pc %h) want pc 8000_1006", pop_pc_q.size(), (pop_pc_q.size() != 0) ? pop_pc_q[0] : 64'h0);
      end
      checks++;
      if (pop_pc_q.size() < 2 || pop_pc_q[1] !== 64'h8000_1008) begin
         errors++; $display("FAIL br_second_word: got %0d pops want second pc 8000_1008", pop_pc_q.size());
      end
   endtask

   task automatic test_flush_prio();
      do_reset();
      imem_req_ready = 1'b1; if_iq_ready = 1'b1; mem_hold = 1'b0;
      step();  // BOOT
      flush = 1'b1; flush_pc = 64'h8000_0100;
      branch_pc_valid = 1'b1; branch_pc = 64'h8000_2000;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL fl_suppress: got %b want 0", imem_req_valid); end
      step();
      flush = 1'b0; branch_pc_valid = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_req_pc !== 64'h8000_0100 || imem_req_epoch !== 2'd1) begin
         errors++; $display("FAIL fl_target: got v=%b pc=%h ep=%0d want v=1 pc=8000_0100 ep=1", imem_req_valid, imem_req_pc, imem_req_epoch);
      end
      clear_logs();
      repeat (6) step();
      checks++; if (pop_pc_q.size() == 0 || pop_pc_q[0] !== 64'h8000_0100) begin errors++; $display("FAIL fl_first_word: got %0d pops want first pc 8000_0100", pop_pc_q.size()); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      imem_req_ready = 1'b1; if_iq_ready = 1'b1; mem_hold = 1'b1;
      step();  // BOOT
      branch_pc_valid = 1'b1; branch_pc = 64'h8000_0040;
      step();
      branch_pc_valid = 1'b0;
      repeat (2) step();
      checks++; if (fire_pc_q.size() !== 2 || fire_pc_q[0] !== 64'h8000_0040 || fire_ep_q[0] !== 2'd1) begin
         errors++; $display("FAIL mid_pre_fires: got %0d fires want 2 starting 8000_0040 ep1", fire_pc_q.size());
      end
      #2;
      RST = 1'b1;
      #1;
      checks++; if (imem_req_valid !== 1'b0 || imem_req_pc !== 64'h8000_0000 || imem_req_epoch !== 2'd0) begin
         errors++; $display("FAIL mid_rst_req: got v=%b pc=%h ep=%0d want v=0 pc=8000_0000 ep=0", imem_req_valid, imem_req_pc, imem_req_epoch);
      end
      checks++; if (if_iq_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_iq: got %b want 0", if_iq_valid); end
      mem_hold = 1'b0;
      mq_pc.delete(); mq_ep.delete();
      imem_rsp_valid = 1'b0; imem_rsp_instr = '0; imem_rsp_epoch = '0;
      @(posedge CLK); #1;
      RST = 1'b0;
      clear_logs();
      repeat (4) step();
      checks++; if (fire_pc_q.size() == 0 || fire_pc_q[0] !== 64'h8000_0000 || fire_ep_q[0] !== 2'd0) begin
         errors++; $display("FAIL mid_restart: got %0d fires want first 8000_0000 ep0", fire_pc_q.size());
      end
   endtask

   initial begin
      RST = 1'b1;
      flush = 1'b0; flush_pc = '0;
      branch_pc_valid = 1'b0; branch_pc = '0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_instr = '0; imem_rsp_epoch = '0;
      if_iq_ready = 1'b0;
      mem_hold = 1'b0;
      max_inflight = 0;
      test_reset();
      test_stream();
      test_stall();
      test_backpressure();
      test_branch();
      test_flush_prio();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
